// File: rtl/corereset_pf_if.sv
// Fabric reset bundle: the reset-qualifying status inputs and the resulting fabric reset.
// The reset generator is the slave; the clock/reset infrastructure is the master.
interface corereset_pf_if;
    logic PLL_LOCK;
    logic SS_BUSY;
    logic INIT_DONE;
    logic FF_US_RESTORE;
    logic FABRIC_RESET_N;

    modport master (
        output PLL_LOCK,
        output SS_BUSY,
        output INIT_DONE,
        output FF_US_RESTORE,
        input  FABRIC_RESET_N
    );

    modport slave (
        input  PLL_LOCK,
        input  SS_BUSY,
        input  INIT_DONE,
        input  FF_US_RESTORE,
        output FABRIC_RESET_N
    );
endinterface

// File: rtl/corereset_pf.sv
// Fabric reset generator: asynchronous assert from EXT_RST_N/PLL_LOCK/INIT_DONE,
// synchronous release to CLK after a synchronizer chain plus a programmable hold.
module corereset_pf #(
    parameter int unsigned SYNC_STAGES = 3,
    parameter int unsigned HOLD_CYCLES = 16
) (
    input  logic            CLK,
    input  logic            EXT_RST_N,
    corereset_pf_if.slave   rst_if
);

    localparam int unsigned CNT_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES);

    // Combined asynchronous assert source for every flop in the block.
    logic arst_n;
    assign arst_n = EXT_RST_N & rst_if.PLL_LOCK & rst_if.INIT_DONE;

    logic [1:0]             ss_busy_q,    ss_busy_d;
    logic [1:0]             ff_restore_q, ff_restore_d;
    logic [SYNC_STAGES-1:0] chain_q,      chain_d;
    logic [CNT_W-1:0]       hold_cnt_q,   hold_cnt_d;
    logic                   fabric_rst_n_q, fabric_rst_n_d;
    logic                   rel_en_c;
    logic                   last_stage_c;

    // Next-state logic for blocker syncs, release chain, hold counter and output.
    always_comb begin
        ss_busy_d      = ss_busy_q;
        ff_restore_d   = ff_restore_q;
        chain_d        = chain_q;
        hold_cnt_d     = hold_cnt_q;
        fabric_rst_n_d = 1'b0;
        rel_en_c       = 1'b0;
        last_stage_c   = chain_q[SYNC_STAGES-1];

        ss_busy_d    = {ss_busy_q[0],    rst_if.SS_BUSY};
        ff_restore_d = {ff_restore_q[0], rst_if.FF_US_RESTORE};

        // arst_n is implied: while it is low every flop here is held in reset.
        rel_en_c = ~ss_busy_q[1] & ~ff_restore_q[1];

        if (rel_en_c) begin
            chain_d = {chain_q[SYNC_STAGES-2:0], 1'b1};
        end else begin
            chain_d = '0;
        end

        if (!last_stage_c) begin
            hold_cnt_d = '0;
        end else if (hold_cnt_q != HOLD_MAX) begin
            hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end

        // Gating with rel_en_c drops the output on the same edge the chain clears.
        fabric_rst_n_d = rel_en_c & last_stage_c & (hold_cnt_q == HOLD_MAX);
    end

    // Blocker synchronizers reset to the blocking value.
    always_ff @(posedge CLK or negedge arst_n) begin
        if (!arst_n) begin
            ss_busy_q    <= 2'b11;
            ff_restore_q <= 2'b11;
        end else begin
            ss_busy_q    <= ss_busy_d;
            ff_restore_q <= ff_restore_d;
        end
    end

    // Release chain, hold counter and output register.
    always_ff @(posedge CLK or negedge arst_n) begin
        if (!arst_n) begin
            chain_q        <= '0;
            hold_cnt_q     <= '0;
            fabric_rst_n_q <= 1'b0;
        end else begin
            chain_q        <= chain_d;
            hold_cnt_q     <= hold_cnt_d;
            fabric_rst_n_q <= fabric_rst_n_d;
        end
    end

    assign rst_if.FABRIC_RESET_N = fabric_rst_n_q;

endmodule

// File: tb/tb_corereset_pf.sv
// Bench for corereset_pf: default-hold and zero-hold instances share one stimulus and
// are checked every cycle against a run-length model of the release rules.
module tb_corereset_pf;

    localparam int S      = 3;
    localparam int H      = 16;
    localparam int THR_A  = S + H + 1;
    localparam int THR_B  = S + 1;
    localparam int LAT_A  = S + H + 3;
    localparam int LAT_B  = S + 3;

    logic clk = 1'b0;
    always #50 clk = ~clk;

    logic ext_rst_n, pll_lock, init_done, ss_busy, ff_restore;

    corereset_pf_if if_a();
    corereset_pf_if if_b();

    assign if_a.PLL_LOCK      = pll_lock;
    assign if_a.INIT_DONE     = init_done;
    assign if_a.SS_BUSY       = ss_busy;
    assign if_a.FF_US_RESTORE = ff_restore;
    assign if_b.PLL_LOCK      = pll_lock;
    assign if_b.INIT_DONE     = init_done;
    assign if_b.SS_BUSY       = ss_busy;
    assign if_b.FF_US_RESTORE = ff_restore;

    corereset_pf #(.SYNC_STAGES(S), .HOLD_CYCLES(H)) dut_a (
        .CLK       (clk),
        .EXT_RST_N (ext_rst_n),
        .rst_if    (if_a.slave)
    );

    corereset_pf #(.SYNC_STAGES(S), .HOLD_CYCLES(0)) dut_b (
        .CLK       (clk),
        .EXT_RST_N (ext_rst_n),
        .rst_if    (if_b.slave)
    );

    // Model: r0 = length of the current run of edges that sampled both blockers low since
    // the last assert; the blockers take two edges to reach release logic, so the output is
    // 1 once the run seen two edges ago covers chain + hold + output register.
    int r0 = 0, r1 = 0, r2 = 0;
    logic m_arst;
    assign m_arst = ext_rst_n & pll_lock & init_done;

    always @(posedge clk or negedge m_arst) begin
        if (!m_arst) begin
            r0 <= 0;
            r1 <= 0;
            r2 <= 0;
        end else begin
            r2 <= r1;
            r1 <= r0;
            r0 <= (!ss_busy && !ff_restore) ? r0 + 1 : 0;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock edge, then compare both instances against the model at the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        check("track_a", if_a.FABRIC_RESET_N, m_arst && (r2 >= THR_A));
        check("track_b", if_b.FABRIC_RESET_N, m_arst && (r2 >= THR_B));
    endtask

    // Edge count (from the next edge) at which each output first rises; -1 if never.
    task automatic measure(output int lat_a, output int lat_b);
        lat_a = -1;
        lat_b = -1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (lat_a < 0 && if_a.FABRIC_RESET_N === 1'b1) lat_a = i;
            if (lat_b < 0 && if_b.FABRIC_RESET_N === 1'b1) lat_b = i;
        end
        check("stays_high_a", if_a.FABRIC_RESET_N, 1'b1);
        check("stays_high_b", if_b.FABRIC_RESET_N, 1'b1);
    endtask

    task automatic set_src(input int src, input logic v);
        case (src)
            0:       ext_rst_n = v;
            1:       pll_lock  = v;
            default: init_done = v;
        endcase
    endtask

    int la, lb;

    initial begin
        ext_rst_n  = 1'b0;
        pll_lock   = 1'b1;
        init_done  = 1'b1;
        ss_busy    = 1'b1;
        ff_restore = 1'b1;
        repeat (3) step();
        check("reset_a", if_a.FABRIC_RESET_N, 1'b0);
        check("reset_b", if_b.FABRIC_RESET_N, 1'b0);
        ext_rst_n = 1'b1;
        repeat (2) step();

        // Each assert source holds reset even with both blockers cleared.
        for (int src = 0; src < 3; src++) begin
            set_src(src, 1'b0);
            #1;
            check("assert_async_a", if_a.FABRIC_RESET_N, 1'b0);
            check("assert_async_b", if_b.FABRIC_RESET_N, 1'b0);
            step();
            ff_restore = 1'b0;
            step();
            ss_busy = 1'b0;
            step();
            check("assert_held_a", if_a.FABRIC_RESET_N, 1'b0);
            check("assert_held_b", if_b.FABRIC_RESET_N, 1'b0);
            ff_restore = 1'b1;
            step();
            set_src(src, 1'b1);
            ss_busy = 1'b1;
            repeat (2) step();
        end

        // Release latency from blockers falling.
        ss_busy    = 1'b0;
        ff_restore = 1'b0;
        measure(la, lb);
        check_int("release_lat_a", la, LAT_A);
        check_int("release_lat_b", lb, LAT_B);

        // SS_BUSY re-blocks within 3 edges, then full latency again.
        ss_busy = 1'b1;
        repeat (3) step();
        check("ss_block_a", if_a.FABRIC_RESET_N, 1'b0);
        check("ss_block_b", if_b.FABRIC_RESET_N, 1'b0);
        ss_busy = 1'b0;
        measure(la, lb);
        check_int("ss_relat_a", la, LAT_A);
        check_int("ss_relat_b", lb, LAT_B);

        // Same with FF_US_RESTORE.
        ff_restore = 1'b1;
        repeat (3) step();
        check("ff_block_a", if_a.FABRIC_RESET_N, 1'b0);
        check("ff_block_b", if_b.FABRIC_RESET_N, 1'b0);
        ff_restore = 1'b0;
        measure(la, lb);
        check_int("ff_relat_a", la, LAT_A);
        check_int("ff_relat_b", lb, LAT_B);

        // 30 ns EXT_RST_N pulse in the middle of the hold count restarts everything.
        ss_busy = 1'b1;
        repeat (3) step();
        ss_busy = 1'b0;
        repeat (12) step();
        check("mid_hold_a", if_a.FABRIC_RESET_N, 1'b0);
        #10 ext_rst_n = 1'b0;
        #1;
        check("glitch_async_a", if_a.FABRIC_RESET_N, 1'b0);
        check("glitch_async_b", if_b.FABRIC_RESET_N, 1'b0);
        #29 ext_rst_n = 1'b1;
        measure(la, lb);
        check_int("glitch_relat_a", la, LAT_A);
        check_int("glitch_relat_b", lb, LAT_B);

        // Random bursts of held input vectors, with occasional sub-cycle assert glitches.
        for (int k = 0; k < 80; k++) begin
            ext_rst_n  = ($urandom_range(0, 7) != 0);
            pll_lock   = ($urandom_range(0, 7) != 0);
            init_done  = ($urandom_range(0, 7) != 0);
            ss_busy    = ($urandom_range(0, 3) == 0);
            ff_restore = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 5) == 0) begin
                #10 pll_lock = 1'b0;
                #20 pll_lock = 1'b1;
            end
            repeat ($urandom_range(1, 30)) step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
